// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between the memory/load path
// and the ALU path. Loads always win the port. ALU writes that lose are parked
// in a small in-order queue and drained on cycles with no load. A load
// squashes any queued ALU write to the same register, because the load is the
// younger producer.
module regfile_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_wb_en,
    input  logic [ADDR_W-1:0] alu_wb_addr,
    input  logic [DATA_W-1:0] alu_wb_data,
    input  logic              mem_wb_en,
    input  logic [ADDR_W-1:0] mem_wb_addr,
    input  logic [DATA_W-1:0] mem_wb_data,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              write_back,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              stall,
    output logic              raw_hazard
);

    localparam int CW = $clog2(DEPTH + 1);

    // Deferred ALU writes. Slot 0 is the oldest entry. Slots at or above
    // count_q hold stale data.
    logic [ADDR_W-1:0] q_addr_q [DEPTH];
    logic [DATA_W-1:0] q_data_q [DEPTH];
    logic [ADDR_W-1:0] q_addr_d [DEPTH];
    logic [DATA_W-1:0] q_data_d [DEPTH];
    logic [CW-1:0]     count_q, count_d;

    logic              write_back_q;
    logic [ADDR_W-1:0] write_addr_q;
    logic [DATA_W-1:0] write_data_q;

    logic              queue_empty;
    logic              deq;
    logic              alu_ok;
    logic              alu_direct;
    logic              alu_enq;
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  keep;
    logic [DEPTH-1:0]  hazard_hit;
    logic [CW-1:0]     pos [DEPTH];
    logic [CW-1:0]     kept_cnt;

    assign queue_empty = (count_q == '0);
    assign stall       = (count_q == CW'(DEPTH));

    // Port selection order: load first, then the queue head, then a direct ALU write.
    assign deq        = !mem_wb_en && !queue_empty;
    assign alu_ok     = alu_wb_en && !stall;
    assign alu_direct = alu_ok && !mem_wb_en && queue_empty;

    // An ALU write that targets the same register as a concurrent load is dropped.
    assign alu_enq    = alu_ok && !alu_direct &&
                        !(mem_wb_en && (alu_wb_addr == mem_wb_addr));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign valid[gi]      = (count_q > CW'(gi));
            // An entry leaves the queue when a load squashes it or when it is the dequeued head.
            assign keep[gi]       = valid[gi]
                                  && !(mem_wb_en && (q_addr_q[gi] == mem_wb_addr))
                                  && !(deq && (gi == 0));
            assign hazard_hit[gi] = valid[gi] &&
                                    ((q_addr_q[gi] == src_addr) || (q_addr_q[gi] == dst_addr));
        end
    endgenerate

    // Each surviving entry moves down to the slot given by the number of
    // surviving entries ahead of it. This keeps the queue compact and in order.
    always_comb begin
        kept_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pos[i] = kept_cnt;
            if (keep[i]) begin
                kept_cnt = kept_cnt + CW'(1);
            end
        end
    end

    assign count_d = alu_enq ? (kept_cnt + CW'(1)) : kept_cnt;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            // Fill this slot with the surviving entry mapped to it. A new ALU
            // write is appended directly after the last surviving entry.
            always_comb begin
                q_addr_d[gi] = q_addr_q[gi];
                q_data_d[gi] = q_data_q[gi];
                for (int i = 0; i < DEPTH; i++) begin
                    if (keep[i] && (pos[i] == CW'(gi))) begin
                        q_addr_d[gi] = q_addr_q[i];
                        q_data_d[gi] = q_data_q[i];
                    end
                end
                if (alu_enq && (kept_cnt == CW'(gi))) begin
                    q_addr_d[gi] = alu_wb_addr;
                    q_data_d[gi] = alu_wb_data;
                end
            end
        end
    endgenerate

    // Queue payload storage. It needs no reset because count_q decides which slots are valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            q_addr_q[i] <= q_addr_d[i];
            q_data_q[i] <= q_data_d[i];
        end
    end

    // Queue occupancy and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            write_back_q <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            count_q      <= count_d;
            write_back_q <= mem_wb_en || deq || alu_direct;
            if (mem_wb_en) begin
                write_addr_q <= mem_wb_addr;
                write_data_q <= mem_wb_data;
            end else if (deq) begin
                write_addr_q <= q_addr_q[0];
                write_data_q <= q_data_q[0];
            end else if (alu_direct) begin
                write_addr_q <= alu_wb_addr;
                write_data_q <= alu_wb_data;
            end
        end
    end

    assign write_back = write_back_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;

    // A hazard exists when a pending write, either queued or on the port this
    // cycle, targets either decode read register.
    assign raw_hazard = (|hazard_hit) ||
                        (write_back_q && ((write_addr_q == src_addr) || (write_addr_q == dst_addr)));

endmodule
